// File: rtl/garegga_cen_pkg.sv
// Shared definitions for the Raizing clock-enable scheduler: game IDs,
// FSM states and the per-game n/m ratio table.
package garegga_cen_pkg;

   localparam int NUM_CH  = 4;
   localparam int RATIO_W = 16;

   localparam logic [1:0] GAME_GAREGGA  = 2'd0;
   localparam logic [1:0] GAME_KINGDMGP = 2'd1;
   localparam logic [1:0] GAME_MAHOUDAI = 2'd2;
   localparam logic [1:0] GAME_SHIPPUMD = 2'd3;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HOLD = 2'd1,
      LOAD = 2'd2
   } state_t;

   typedef struct packed {
      logic [RATIO_W-1:0] n;
      logic [RATIO_W-1:0] m;
   } ratio_t;

   function automatic ratio_t mk_ratio(input int unsigned n, input int unsigned m);
      ratio_t r;
      r.n = RATIO_W'(n);
      r.m = RATIO_W'(m);
      return r;
   endfunction

   // Channels: 0 Z80, 1 OKI, 2 GP9001, 3 aux. Only OKI and aux differ per game.
   function automatic ratio_t ratio_lookup(input logic [1:0] game, input logic [1:0] ch);
      ratio_t r;
      r = mk_ratio(1, 96);
      case (ch)
         2'd0: r = mk_ratio(1, 24);
         2'd1: begin
            case (game)
               GAME_KINGDMGP: r = mk_ratio(9, 256);
               GAME_MAHOUDAI: r = mk_ratio(1, 12672);
               GAME_SHIPPUMD: r = mk_ratio(1, 96);
               default:       r = mk_ratio(1, 48);
            endcase
         end
         2'd2: r = mk_ratio(9, 128);
         default: begin
            case (game)
               GAME_KINGDMGP: r = mk_ratio(9, 512);
               GAME_SHIPPUMD: r = mk_ratio(1, 48);
               default:       r = mk_ratio(1, 96);
            endcase
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/garegga_cen_chan.sv
// One fractional clock-enable channel: accumulates n per active cycle and
// emits CEN on wrap past m and CENB on crossing m/2.
import garegga_cen_pkg::*;

module garegga_cen_chan #(
   parameter int WC = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          run,
   input  logic          pause,
   input  logic          clr,
   input  logic [WC-1:0] n,
   input  logic [WC-1:0] m,
   output logic          cen,
   output logic          cenb
);

   logic [WC-1:0] acc;
   logic [WC-1:0] acc_nxt;
   logic [WC:0]   sum;
   logic [WC:0]   half;
   logic          hit;
   logic          half_hit;

   // Table guarantees n < m, so sum - m always fits back into WC bits.
   always_comb begin
      sum      = {1'b0, acc} + {1'b0, n};
      half     = {2'b00, m[WC-1:1]};
      hit      = (sum >= {1'b0, m});
      half_hit = ({1'b0, acc} < half) && (sum >= half) && !hit;
      acc_nxt  = hit ? (sum[WC-1:0] - m) : sum[WC-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc  <= '0;
         cen  <= 1'b0;
         cenb <= 1'b0;
      end else if (clr) begin
         acc  <= '0;
         cen  <= 1'b0;
         cenb <= 1'b0;
      end else if (run && !pause) begin
         acc  <= acc_nxt;
         cen  <= hit;
         cenb <= half_hit;
      end else begin
         cen  <= 1'b0;
         cenb <= 1'b0;
      end
   end

endmodule

// File: rtl/garegga_cen_sched.sv
// Per-game clock-enable scheduler: selects the ratio set for the current
// game and sequences a quiet HOLD/LOAD reconfiguration on every change.
import garegga_cen_pkg::*;

module garegga_cen_sched #(
   parameter int WC       = 16,
   parameter int HOLD_CYC = 4
) (
   input  logic       CLK96,
   input  logic       RESETn,
   input  logic [2:0] GAME,
   input  logic       CFG_REQ,
   input  logic       PAUSE,
   input  logic [3:0] PAUSE_MASK,
   output logic [3:0] CEN,
   output logic [3:0] CENB,
   output logic       BUSY,
   output logic       CFG_ACK
);

   localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYC - 1);

   state_t        state;
   logic [1:0]    game_q;
   logic [1:0]    game_prev;
   logic [1:0]    cfg_game;
   logic [7:0]    hold_cnt;
   logic [WC-1:0] n_q   [NUM_CH];
   logic [WC-1:0] m_q   [NUM_CH];
   ratio_t        tbl_r [NUM_CH];
   logic          trigger;
   logic          restart;
   logic          chan_run;
   logic          chan_clr;

   // Unused game codes 4..7 fold onto garegga.
   always_ff @(posedge CLK96 or negedge RESETn) begin
      if (!RESETn) begin
         game_q    <= GAME_GAREGGA;
         game_prev <= GAME_GAREGGA;
      end else begin
         game_q    <= GAME[2] ? GAME_GAREGGA : GAME[1:0];
         game_prev <= game_q;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         tbl_r[i] = ratio_lookup(game_q, 2'(i));
      end
   end

   // In RUN a trigger also gates the channels, so nothing fires on the detect edge.
   always_comb begin
      trigger  = CFG_REQ || (game_q != cfg_game);
      restart  = CFG_REQ || (game_q != game_prev);
      chan_run = (state == RUN) && !trigger;
      chan_clr = (state == LOAD);
   end

   always_ff @(posedge CLK96 or negedge RESETn) begin
      if (!RESETn) begin
         state    <= LOAD;
         cfg_game <= GAME_GAREGGA;
         hold_cnt <= '0;
         BUSY     <= 1'b1;
         CFG_ACK  <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            n_q[i] <= '0;
            m_q[i] <= '0;
         end
      end else begin
         CFG_ACK <= 1'b0;
         case (state)
            RUN: begin
               if (trigger) begin
                  state    <= HOLD;
                  hold_cnt <= HOLD_INIT;
                  BUSY     <= 1'b1;
               end
            end
            HOLD: begin
               if (restart) begin
                  hold_cnt <= HOLD_INIT;
               end else if (hold_cnt == 8'd0) begin
                  state <= LOAD;
               end else begin
                  hold_cnt <= hold_cnt - 8'd1;
               end
            end
            LOAD: begin
               cfg_game <= game_q;
               for (int i = 0; i < NUM_CH; i++) begin
                  n_q[i] <= WC'(tbl_r[i].n);
                  m_q[i] <= WC'(tbl_r[i].m);
               end
               state   <= RUN;
               BUSY    <= 1'b0;
               CFG_ACK <= 1'b1;
            end
            default: begin
               state <= LOAD;
               BUSY  <= 1'b1;
            end
         endcase
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      garegga_cen_chan #(
         .WC(WC)
      ) u_chan (
         .clk  (CLK96),
         .rst_n(RESETn),
         .run  (chan_run),
         .pause(PAUSE & PAUSE_MASK[i]),
         .clr  (chan_clr),
         .n    (n_q[i]),
         .m    (m_q[i]),
         .cen  (CEN[i]),
         .cenb (CENB[i])
      );
   end

endmodule

// File: tb/tb_garegga_cen_sched.sv
// Directed bench for garegga_cen_sched: reset sequence, ratio pulse positions,
// reconfiguration latency, pause, HOLD restart and asynchronous reset.
module tb_garegga_cen_sched;

   logic       CLK96 = 1'b0;
   logic       RESETn = 1'b0;
   logic [2:0] GAME = 3'd0;
   logic       CFG_REQ = 1'b0;
   logic       PAUSE = 1'b0;
   logic [3:0] PAUSE_MASK = 4'b0000;
   logic [3:0] CEN;
   logic [3:0] CENB;
   logic       BUSY;
   logic       CFG_ACK;

   int total = 0;
   int bad   = 0;

   garegga_cen_sched #(
      .WC(16),
      .HOLD_CYC(4)
   ) dut (
      .CLK96     (CLK96),
      .RESETn    (RESETn),
      .GAME      (GAME),
      .CFG_REQ   (CFG_REQ),
      .PAUSE     (PAUSE),
      .PAUSE_MASK(PAUSE_MASK),
      .CEN       (CEN),
      .CENB      (CENB),
      .BUSY      (BUSY),
      .CFG_ACK   (CFG_ACK)
   );

   always #5 CLK96 = ~CLK96;

   task automatic tick();
      @(posedge CLK96);
      #1;
   endtask

   task automatic test_reset();
      int c0, c2, c3, last2;
      RESETn = 1'b0;
      GAME   = 3'd0;
      repeat (2) tick();
      total++;
      if ({CEN, CENB, BUSY, CFG_ACK} !== 10'b0000_0000_10) begin
         bad++;
         $display("[TB] FAIL reset_outputs got=%b want=%b", {CEN, CENB, BUSY, CFG_ACK}, 10'b0000_0000_10);
      end
      RESETn = 1'b1;
      tick();
      total++;
      if (CFG_ACK !== 1'b1 || BUSY !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_entry_ack got ack=%b busy=%b want ack=1 busy=0", CFG_ACK, BUSY);
      end
      c0 = 0; c2 = 0; c3 = 0; last2 = 0;
      for (int k = 1; k <= 128; k++) begin
         tick();
         if (k == 2) begin
            total++;
            if (CFG_ACK !== 1'b0) begin
               bad++;
               $display("[TB] FAIL ack_width got=%b want=0", CFG_ACK);
            end
         end
         if (k == 24 || k == 48 || k == 72) begin
            total++;
            if (CEN[0] !== 1'b1) begin
               bad++;
               $display("[TB] FAIL ch0_pulse_at_%0d got=%b want=1", k, CEN[0]);
            end
         end
         if (k == 12 || k == 36) begin
            total++;
            if (CENB[0] !== 1'b1) begin
               bad++;
               $display("[TB] FAIL ch0_cenb_at_%0d got=%b want=1", k, CENB[0]);
            end
         end
         if (k == 96) begin
            total++;
            if (CEN[3] !== 1'b1) begin
               bad++;
               $display("[TB] FAIL ch3_pulse_at_96 got=%b want=1", CEN[3]);
            end
         end
         if (CEN[2] === 1'b1) begin
            if (last2 != 0) begin
               total++;
               if ((k - last2) != 14 && (k - last2) != 15) begin
                  bad++;
                  $display("[TB] FAIL ch2_spacing got=%0d want=14or15", k - last2);
               end
            end
            last2 = k;
         end
         c0 += int'(CEN[0]);
         c2 += int'(CEN[2]);
         c3 += int'(CEN[3]);
      end
      total++;
      if (c0 != 5 || c2 != 9 || c3 != 1) begin
         bad++;
         $display("[TB] FAIL reset_counts got ch0=%0d ch2=%0d ch3=%0d want 5 9 1", c0, c2, c3);
      end
   endtask

   task automatic test_game_change();
      int c0, c1, c2, c3;
      GAME = 3'd1;
      tick();
      total++;
      if (BUSY !== 1'b0) begin
         bad++;
         $display("[TB] FAIL detect_busy got=%b want=0", BUSY);
      end
      for (int j = 1; j <= 6; j++) begin
         tick();
         total++;
         if (CEN !== 4'b0000 || CENB !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL quiet_c%0d got cen=%b cenb=%b want 0000", j, CEN, CENB);
         end
         total++;
         if (BUSY !== (j != 6) || CFG_ACK !== (j == 6)) begin
            bad++;
            $display("[TB] FAIL reconf_c%0d got busy=%b ack=%b want busy=%b ack=%b", j, BUSY, CFG_ACK, j != 6, j == 6);
         end
      end
      c0 = 0; c1 = 0; c2 = 0; c3 = 0;
      for (int k = 1; k <= 256; k++) begin
         tick();
         c0 += int'(CEN[0]);
         c1 += int'(CEN[1]);
         c2 += int'(CEN[2]);
         c3 += int'(CEN[3]);
      end
      total++;
      if (c1 != 9) begin
         bad++;
         $display("[TB] FAIL g1_ch1_count got=%0d want=9", c1);
      end
      total++;
      if (c0 != 10 || c2 != 18 || c3 != 4) begin
         bad++;
         $display("[TB] FAIL g1_other_counts got %0d %0d %0d want 10 18 4", c0, c2, c3);
      end
   endtask

   task automatic test_pause();
      int got, c0, c1, b1, c3, f1, fb1;
      GAME = 3'd3;
      got  = 0;
      for (int j = 0; j < 20 && got == 0; j++) begin
         tick();
         if (CFG_ACK === 1'b1) got = 1;
      end
      total++;
      if (got == 0) begin
         bad++;
         $display("[TB] FAIL g3_ack_timeout got=0 want=1");
      end
      repeat (40) tick();
      PAUSE      = 1'b1;
      PAUSE_MASK = 4'b0010;
      c0 = 0; c1 = 0; b1 = 0; c3 = 0;
      for (int k = 1; k <= 100; k++) begin
         tick();
         if (k == 8) begin
            total++;
            if (CEN[0] !== 1'b1) begin
               bad++;
               $display("[TB] FAIL pause_ch0_at_48 got=%b want=1", CEN[0]);
            end
         end
         c0 += int'(CEN[0]);
         c1 += int'(CEN[1]);
         b1 += int'(CENB[1]);
         c3 += int'(CEN[3]);
      end
      total++;
      if (c1 != 0 || b1 != 0) begin
         bad++;
         $display("[TB] FAIL paused_ch1 got cen=%0d cenb=%0d want 0 0", c1, b1);
      end
      total++;
      if (c0 != 4 || c3 != 2) begin
         bad++;
         $display("[TB] FAIL unpaused_counts got ch0=%0d ch3=%0d want 4 2", c0, c3);
      end
      PAUSE      = 1'b0;
      PAUSE_MASK = 4'b0000;
      f1 = 0; fb1 = 0;
      for (int k = 1; k <= 60; k++) begin
         tick();
         if (CEN[1] === 1'b1 && f1 == 0) f1 = k;
         if (CENB[1] === 1'b1 && fb1 == 0) fb1 = k;
      end
      total++;
      if (f1 != 56 || fb1 != 8) begin
         bad++;
         $display("[TB] FAIL resume_phase got cen@%0d cenb@%0d want 56 8", f1, fb1);
      end
   endtask

   task automatic test_cfg_req();
      CFG_REQ = 1'b1;
      tick();
      CFG_REQ = 1'b0;
      total++;
      if (BUSY !== 1'b1 || CEN !== 4'b0000) begin
         bad++;
         $display("[TB] FAIL req_hold_entry got busy=%b cen=%b want 1 0000", BUSY, CEN);
      end
      for (int j = 2; j <= 6; j++) begin
         tick();
         total++;
         if (CFG_ACK !== (j == 6)) begin
            bad++;
            $display("[TB] FAIL req_ack_c%0d got=%b want=%b", j, CFG_ACK, j == 6);
         end
      end
   endtask

   task automatic test_hold_restart();
      CFG_REQ = 1'b1;
      tick();
      CFG_REQ = 1'b0;
      tick();
      CFG_REQ = 1'b1;
      tick();
      CFG_REQ = 1'b0;
      for (int j = 2; j <= 6; j++) begin
         tick();
         total++;
         if (CFG_ACK !== (j == 6) || BUSY !== (j != 6)) begin
            bad++;
            $display("[TB] FAIL restart_p%0d got ack=%b busy=%b want ack=%b busy=%b", j, CFG_ACK, BUSY, j == 6, j != 6);
         end
      end
   endtask

   task automatic test_async_reset();
      int f0;
      CFG_REQ = 1'b1;
      tick();
      CFG_REQ = 1'b0;
      tick();
      GAME   = 3'd0;
      RESETn = 1'b0;
      #1;
      total++;
      if ({CEN, CENB, BUSY, CFG_ACK} !== 10'b0000_0000_10) begin
         bad++;
         $display("[TB] FAIL hold_reset got=%b want=%b", {CEN, CENB, BUSY, CFG_ACK}, 10'b0000_0000_10);
      end
      tick();
      RESETn = 1'b1;
      tick();
      total++;
      if (CFG_ACK !== 1'b1 || BUSY !== 1'b0) begin
         bad++;
         $display("[TB] FAIL hold_reset_entry got ack=%b busy=%b want 1 0", CFG_ACK, BUSY);
      end
      f0 = 0;
      for (int k = 1; k <= 24; k++) begin
         tick();
         if (CEN[0] === 1'b1 && f0 == 0) f0 = k;
      end
      total++;
      if (f0 != 24 || BUSY !== 1'b0) begin
         bad++;
         $display("[TB] FAIL run_before_reset got ch0@%0d busy=%b want 24 0", f0, BUSY);
      end
      RESETn = 1'b0;
      #1;
      total++;
      if (CEN !== 4'b0000 || BUSY !== 1'b1) begin
         bad++;
         $display("[TB] FAIL run_async_reset got cen=%b busy=%b want 0000 1", CEN, BUSY);
      end
      tick();
      RESETn = 1'b1;
      tick();
      total++;
      if (CFG_ACK !== 1'b1) begin
         bad++;
         $display("[TB] FAIL run_reset_entry got=%b want=1", CFG_ACK);
      end
   endtask

   task automatic test_game_alias();
      int first [4];
      int want  [4];
      int busy_seen;
      want[0] = 24; want[1] = 48; want[2] = 15; want[3] = 96;
      RESETn = 1'b0;
      GAME   = 3'd5;
      repeat (2) tick();
      RESETn = 1'b1;
      tick();
      total++;
      if (CFG_ACK !== 1'b1) begin
         bad++;
         $display("[TB] FAIL alias_entry_ack got=%b want=1", CFG_ACK);
      end
      for (int i = 0; i < 4; i++) first[i] = 0;
      busy_seen = 0;
      for (int k = 1; k <= 100; k++) begin
         tick();
         if (BUSY !== 1'b0) busy_seen = 1;
         for (int i = 0; i < 4; i++) begin
            if (CEN[i] === 1'b1 && first[i] == 0) first[i] = k;
         end
      end
      total++;
      if (busy_seen != 0) begin
         bad++;
         $display("[TB] FAIL alias_retrigger got busy_seen=%0d want=0", busy_seen);
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (first[i] != want[i]) begin
            bad++;
            $display("[TB] FAIL alias_ch%0d_first got=%0d want=%0d", i, first[i], want[i]);
         end
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_game_change();
      test_pause();
      test_cfg_req();
      test_hold_restart();
      test_async_reset();
      test_game_alias();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
